// File: rtl/calc_pkg.sv
// Shared types and constants for the PS/2 calculator controller: FSM states,
// ALU opcodes, scan-code set 2 constants and the decoded key class.
package calc_pkg;

   typedef enum logic [2:0] {
      StA    = 3'd0,
      StB    = 3'd1,
      StExec = 3'd2,
      StShow = 3'd3,
      StErr  = 3'd4
   } calc_state_e;

   typedef enum logic [2:0] {
      KeyNone,
      KeyDigit,
      KeyOp,
      KeyEnter,
      KeyClear
   } key_class_e;

   localparam logic [1:0] OpAdd = 2'd0;
   localparam logic [1:0] OpSub = 2'd1;
   localparam logic [1:0] OpMul = 2'd2;
   localparam logic [1:0] OpDiv = 2'd3;

   localparam logic [7:0] CodeBreak = 8'hF0;
   localparam logic [7:0] CodeExt   = 8'hE0;
   localparam logic [7:0] CodePlus  = 8'h79;
   localparam logic [7:0] CodeMinus = 8'h7B;
   localparam logic [7:0] CodeMul   = 8'h7C;
   localparam logic [7:0] CodeDiv   = 8'h4A;
   localparam logic [7:0] CodeEnter = 8'h5A;
   localparam logic [7:0] CodeClear = 8'h76;
   localparam logic [7:0] CodeD0    = 8'h70;
   localparam logic [7:0] CodeD1    = 8'h69;
   localparam logic [7:0] CodeD2    = 8'h72;
   localparam logic [7:0] CodeD3    = 8'h7A;
   localparam logic [7:0] CodeD4    = 8'h6B;
   localparam logic [7:0] CodeD5    = 8'h73;
   localparam logic [7:0] CodeD6    = 8'h74;
   localparam logic [7:0] CodeD7    = 8'h6C;
   localparam logic [7:0] CodeD8    = 8'h75;
   localparam logic [7:0] CodeD9    = 8'h7D;

   // Returns {hit, digit} for a keypad digit scan code.
   function automatic logic [4:0] scan_digit(input logic [7:0] code);
      logic [4:0] res;
      res = 5'd0;
      case (code)
         CodeD0:  res = {1'b1, 4'd0};
         CodeD1:  res = {1'b1, 4'd1};
         CodeD2:  res = {1'b1, 4'd2};
         CodeD3:  res = {1'b1, 4'd3};
         CodeD4:  res = {1'b1, 4'd4};
         CodeD5:  res = {1'b1, 4'd5};
         CodeD6:  res = {1'b1, 4'd6};
         CodeD7:  res = {1'b1, 4'd7};
         CodeD8:  res = {1'b1, 4'd8};
         CodeD9:  res = {1'b1, 4'd9};
         default: res = 5'd0;
      endcase
      return res;
   endfunction

endpackage

// File: rtl/calc_ctrl_if.sv
// ALU handshake bundle between the calculator controller (master) and the
// arithmetic unit (slave).
interface calc_ctrl_if #(
   parameter int unsigned W = 16
);
   logic [W-1:0] alu_a;
   logic [W-1:0] alu_b;
   logic [1:0]   alu_op;
   logic         alu_start;
   logic         alu_done;
   logic [W-1:0] alu_result;
   logic         alu_err;

   modport master (
      output alu_a, alu_b, alu_op, alu_start,
      input  alu_done, alu_result, alu_err
   );

   modport slave (
      input  alu_a, alu_b, alu_op, alu_start,
      output alu_done, alu_result, alu_err
   );
endinterface

// File: rtl/calc_key_decode.sv
// Scan-code byte decoder: tracks F0 (break) / E0 (extended) prefixes and maps
// make codes to key classes. Purely byte-driven; knows nothing of the FSM.
module calc_key_decode
   import calc_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       code_valid,
   input  logic [7:0] code,
   output logic       key_valid,
   output key_class_e key_class,
   output logic [3:0] key_digit,
   output logic [1:0] key_op
);

   logic       brk_q, brk_d;
   logic       ext_q, ext_d;
   logic [4:0] dig;

   always_comb begin
      brk_d     = brk_q;
      ext_d     = ext_q;
      key_class = KeyNone;
      key_digit = 4'd0;
      key_op    = OpAdd;
      dig       = scan_digit(code);
      if (code_valid) begin
         if (code == CodeBreak) begin
            brk_d = 1'b1;
         end else if (code == CodeExt) begin
            ext_d = 1'b1;
         end else begin
            brk_d = 1'b0;
            ext_d = 1'b0;
            // Release bytes are swallowed whole.
            if (!brk_q) begin
               if (ext_q) begin
                  if (code == CodeDiv) begin
                     key_class = KeyOp;
                     key_op    = OpDiv;
                  end else if (code == CodeEnter) begin
                     key_class = KeyEnter;
                  end
               end else if (dig[4]) begin
                  key_class = KeyDigit;
                  key_digit = dig[3:0];
               end else begin
                  case (code)
                     CodePlus:  begin key_class = KeyOp; key_op = OpAdd; end
                     CodeMinus: begin key_class = KeyOp; key_op = OpSub; end
                     CodeMul:   begin key_class = KeyOp; key_op = OpMul; end
                     CodeEnter: key_class = KeyEnter;
                     CodeClear: key_class = KeyClear;
                     default:   key_class = KeyNone;
                  endcase
               end
            end
         end
      end
      key_valid = (key_class != KeyNone);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         brk_q <= 1'b0;
         ext_q <= 1'b0;
      end else begin
         brk_q <= brk_d;
         ext_q <= ext_d;
      end
   end

endmodule

// File: rtl/calc_ctrl.sv
// PS/2 calculator sequencer: builds operands A/B, runs one guarded ALU
// handshake and drives the display. Define CALC_CHAIN_EN to chain from a result.
module calc_ctrl
   import calc_pkg::*;
#(
   parameter int unsigned DIGITS  = 4,
   parameter int unsigned W       = 16,
   parameter int unsigned TIMEOUT = 1000
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         code_valid,
   input  logic [7:0]   code,
   calc_ctrl_if.master  alu,
   output logic [W-1:0] disp_value,
   output logic         disp_neg,
   output logic         disp_err,
   output logic [2:0]   state_o
);

   localparam int unsigned CntW = $clog2(DIGITS + 1);
   localparam int unsigned TmoW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [CntW-1:0] MaxCnt  = CntW'(DIGITS);
   localparam logic [TmoW-1:0] TmoLast = TmoW'(TIMEOUT - 1);

   calc_state_e     state_q, state_d;
   logic [W-1:0]    acc_a_q, acc_a_d;
   logic [W-1:0]    acc_b_q, acc_b_d;
   logic [W-1:0]    result_q, result_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic [1:0]      op_q, op_d;
   logic [TmoW-1:0] tmo_q, tmo_d;
   logic            clr;

   logic       key_valid;
   key_class_e key_class;
   logic [3:0] key_digit;
   logic [1:0] key_op;

   calc_key_decode u_key_decode (
      .clk        (clk),
      .rst        (rst),
      .code_valid (code_valid),
      .code       (code),
      .key_valid  (key_valid),
      .key_class  (key_class),
      .key_digit  (key_digit),
      .key_op     (key_op)
   );

   always_comb begin
      state_d  = state_q;
      acc_a_d  = acc_a_q;
      acc_b_d  = acc_b_q;
      result_d = result_q;
      cnt_d    = cnt_q;
      op_d     = op_q;
      tmo_d    = tmo_q;
      clr      = 1'b0;
      unique case (state_q)
         StA: if (key_valid) begin
            unique case (key_class)
               KeyDigit: if (cnt_q < MaxCnt) begin
                  acc_a_d = acc_a_q * W'(10) + W'(key_digit);
                  cnt_d   = cnt_q + CntW'(1);
               end
               KeyOp: if (cnt_q != '0) begin
                  op_d    = key_op;
                  cnt_d   = '0;
                  acc_b_d = '0;
                  state_d = StB;
               end
               KeyClear: clr = 1'b1;
               default: ;
            endcase
         end
         StB: if (key_valid) begin
            unique case (key_class)
               KeyDigit: if (cnt_q < MaxCnt) begin
                  acc_b_d = acc_b_q * W'(10) + W'(key_digit);
                  cnt_d   = cnt_q + CntW'(1);
               end
               KeyOp: if (cnt_q == '0) op_d = key_op;
               KeyEnter: if (cnt_q != '0) begin
                  tmo_d   = '0;
                  state_d = StExec;
               end
               KeyClear: clr = 1'b1;
               default: ;
            endcase
         end
         // Keys are dropped here; done beats a coincident timeout.
         StExec: begin
            if (alu.alu_done) begin
               if (alu.alu_err) begin
                  state_d = StErr;
               end else begin
                  result_d = alu.alu_result;
                  state_d  = StShow;
               end
            end else if (tmo_q == TmoLast) begin
               state_d = StErr;
            end else begin
               tmo_d = tmo_q + TmoW'(1);
            end
         end
         StShow: if (key_valid) begin
            unique case (key_class)
               KeyDigit: begin
                  acc_a_d = W'(key_digit);
                  acc_b_d = '0;
                  cnt_d   = CntW'(1);
                  op_d    = OpAdd;
                  state_d = StA;
               end
`ifdef CALC_CHAIN_EN
               KeyOp: begin
                  acc_a_d = result_q;
                  acc_b_d = '0;
                  op_d    = key_op;
                  cnt_d   = '0;
                  state_d = StB;
               end
`endif
               KeyClear: clr = 1'b1;
               default: ;
            endcase
         end
         StErr: if (key_valid && key_class == KeyClear) clr = 1'b1;
         default: state_d = StA;
      endcase
      if (clr) begin
         state_d = StA;
         acc_a_d = '0;
         acc_b_d = '0;
         cnt_d   = '0;
         op_d    = OpAdd;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= StA;
         acc_a_q  <= '0;
         acc_b_q  <= '0;
         result_q <= '0;
         cnt_q    <= '0;
         op_q     <= OpAdd;
         tmo_q    <= '0;
      end else begin
         state_q  <= state_d;
         acc_a_q  <= acc_a_d;
         acc_b_q  <= acc_b_d;
         result_q <= result_d;
         cnt_q    <= cnt_d;
         op_q     <= op_d;
         tmo_q    <= tmo_d;
      end
   end

   assign alu.alu_a     = acc_a_q;
   assign alu.alu_b     = acc_b_q;
   assign alu.alu_op    = op_q;
   assign alu.alu_start = (state_q == StExec) && (tmo_q == '0);

   // In EXEC the display keeps showing B, which was on screen when Enter hit.
   always_comb begin
      disp_value = '0;
      unique case (state_q)
         StA:     disp_value = acc_a_q;
         StB:     disp_value = (cnt_q != '0) ? acc_b_q : acc_a_q;
         StExec:  disp_value = acc_b_q;
         StShow:  disp_value = result_q;
         default: disp_value = '0;
      endcase
   end

   assign disp_neg = (state_q == StShow) && result_q[W-1];
   assign disp_err = (state_q == StErr);
   assign state_o  = state_q;

endmodule

// File: tb/tb_calc_ctrl.sv
// Randomised bench for calc_ctrl against a keystroke-level reference model,
// with the bench acting as the ALU (variable latency, errors, timeouts).
module tb_calc_ctrl;

   localparam int TO = 20;
   localparam int SA = 0, SB = 1, SEXEC = 2, SSHOW = 3, SERR = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        code_valid = 1'b0;
   logic [7:0]  code = 8'h00;
   logic [15:0] disp_value;
   logic        disp_neg, disp_err;
   logic [2:0]  state_o;

   calc_ctrl_if #(.W(16)) alu_if ();

   calc_ctrl #(.DIGITS(4), .W(16), .TIMEOUT(TO)) dut (
      .clk        (clk),
      .rst        (rst),
      .code_valid (code_valid),
      .code       (code),
      .alu        (alu_if),
      .disp_value (disp_value),
      .disp_neg   (disp_neg),
      .disp_err   (disp_err),
      .state_o    (state_o)
   );

   always #5 clk = ~clk;

   int n_total = 0;
   int n_bad   = 0;

   logic [7:0] dtab [10];

   // Reference model state.
   int m_st, m_a, m_b, m_cnt, m_op, m_res, m_hold;
   bit m_brk, m_ext;

   // ALU behaviour for the next execution.
   int         exec_lat;
   bit         exec_err;
   bit         rand_exec_bytes;
   logic [7:0] exec_bytes[$];

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic void model_reset();
      m_st = SA; m_a = 0; m_b = 0; m_cnt = 0; m_op = 0; m_res = 0; m_hold = 0;
      m_brk = 0; m_ext = 0;
   endfunction

   function automatic void model_clear();
      m_st = SA; m_a = 0; m_b = 0; m_cnt = 0; m_op = 0;
   endfunction

   // 0 none, 1 digit, 2 operator, 3 enter, 4 clear
   function automatic int classify(input logic [7:0] b, input bit ext, output int val);
      val = 0;
      if (ext) begin
         if (b == 8'h4A) begin val = 3; return 2; end
         if (b == 8'h5A) return 3;
         return 0;
      end
      for (int i = 0; i < 10; i++) if (dtab[i] == b) begin val = i; return 1; end
      if (b == 8'h79) begin val = 0; return 2; end
      if (b == 8'h7B) begin val = 1; return 2; end
      if (b == 8'h7C) begin val = 2; return 2; end
      if (b == 8'h5A) return 3;
      if (b == 8'h76) return 4;
      return 0;
   endfunction

   function automatic void model_byte(input logic [7:0] b);
      bit pb, pe;
      int kind, val;
      if (b == 8'hF0) begin m_brk = 1; return; end
      if (b == 8'hE0) begin m_ext = 1; return; end
      pb = m_brk; pe = m_ext; m_brk = 0; m_ext = 0;
      if (pb || m_st == SEXEC) return;
      kind = classify(b, pe, val);
      case (m_st)
         SA: begin
            if (kind == 1 && m_cnt < 4) begin m_a = m_a * 10 + val; m_cnt++; end
            else if (kind == 2 && m_cnt > 0) begin m_op = val; m_cnt = 0; m_b = 0; m_st = SB; end
            else if (kind == 4) model_clear();
         end
         SB: begin
            if (kind == 1 && m_cnt < 4) begin m_b = m_b * 10 + val; m_cnt++; end
            else if (kind == 2 && m_cnt == 0) m_op = val;
            else if (kind == 3 && m_cnt > 0) begin m_hold = m_b; m_st = SEXEC; end
            else if (kind == 4) model_clear();
         end
         SSHOW: begin
            if (kind == 1) begin m_a = val; m_b = 0; m_cnt = 1; m_op = 0; m_st = SA; end
            else if (kind == 4) model_clear();
`ifdef CALC_CHAIN_EN
            else if (kind == 2) begin m_a = m_res; m_b = 0; m_op = val; m_cnt = 0; m_st = SB; end
`endif
         end
         SERR: if (kind == 4) model_clear();
         default: ;
      endcase
   endfunction

   function automatic int exp_disp();
      case (m_st)
         SA:      return m_a;
         SB:      return (m_cnt > 0) ? m_b : m_a;
         SEXEC:   return m_hold;
         SSHOW:   return m_res;
         default: return 0;
      endcase
   endfunction

   task automatic cycle();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic check_outputs();
      logic [31:0] r;
      r = m_res;
      check_eq("state", state_o, m_st);
      check_eq("disp_value", disp_value, exp_disp());
      check_eq("disp_err", disp_err, m_st == SERR);
      check_eq("disp_neg", disp_neg, (m_st == SSHOW) && r[15]);
      check_eq("alu_start_idle", alu_if.alu_start, 0);
   endtask

   task automatic run_exec();
      int         x;
      logic [15:0] r;
      bit         e, timed, sent;
      logic [7:0] b;
      e = exec_err;
      case (m_op)
         0: x = m_a + m_b;
         1: x = m_a - m_b;
         2: x = m_a * m_b;
         default: begin
            if (m_b == 0) begin x = 0; e = 1; end
            else x = m_a / m_b;
         end
      endcase
      r = x[15:0];
      timed = 0;
      for (int k = 0; k < TO; k++) begin
         check_eq("exec_state", state_o, SEXEC);
         check_eq("alu_start", alu_if.alu_start, k == 0);
         check_eq("exec_disp", disp_value, m_hold);
         if (k == 0) begin
            check_eq("alu_a", alu_if.alu_a, m_a);
            check_eq("alu_b", alu_if.alu_b, m_b);
            check_eq("alu_op", alu_if.alu_op, m_op);
         end
         alu_if.alu_done   = (k == exec_lat);
         alu_if.alu_result = r;
         alu_if.alu_err    = e;
         sent = 0;
         b = 8'h00;
         if (exec_bytes.size() > 0) begin
            b = exec_bytes.pop_front(); sent = 1;
         end else if (rand_exec_bytes && $urandom_range(0, 3) == 0) begin
            b = 8'($urandom_range(0, 255)); sent = 1;
         end
         code_valid = sent;
         code = b;
         cycle();
         code_valid = 0;
         alu_if.alu_done = 0;
         if (sent) model_byte(b);
         if (k == exec_lat) begin
            m_st = e ? SERR : SSHOW;
            if (!e) m_res = r;
            break;
         end else if (k == TO - 1) begin
            m_st = SERR;
            timed = 1;
         end
      end
      check_outputs();
      if (timed) begin
         alu_if.alu_done = 1; alu_if.alu_err = 0;
         cycle();
         alu_if.alu_done = 0;
         check_outputs();
      end
   endtask

   task automatic send_byte(input logic [7:0] b);
      code_valid = 1;
      code = b;
      cycle();
      code_valid = 0;
      model_byte(b);
      if (m_st == SEXEC) run_exec();
      else check_outputs();
   endtask

   task automatic send_seq(input logic [7:0] seq[$]);
      foreach (seq[i]) send_byte(seq[i]);
   endtask

   task automatic send_random_token();
      int r;
      logic [7:0] q[$];
      logic [7:0] opc[3];
      opc[0] = 8'h79; opc[1] = 8'h7B; opc[2] = 8'h7C;
      r = $urandom_range(0, 99);
      q = {};
      if (r < 45)      q.push_back(dtab[$urandom_range(0, 9)]);
      else if (r < 55) q.push_back(opc[$urandom_range(0, 2)]);
      else if (r < 60) begin q.push_back(8'hE0); q.push_back(8'h4A); end
      else if (r < 70) q.push_back(8'h5A);
      else if (r < 73) begin q.push_back(8'hE0); q.push_back(8'h5A); end
      else if (r < 76) q.push_back(8'h76);
      else if (r < 86) begin q.push_back(8'hF0); q.push_back(dtab[$urandom_range(0, 9)]); end
      else if (r < 92) begin q.push_back(8'hE0); q.push_back(dtab[$urandom_range(0, 9)]); end
      else             q.push_back(8'($urandom_range(0, 255)));
      r = $urandom_range(0, 99);
      if (r < 70)      exec_lat = $urandom_range(0, 8);
      else if (r < 85) exec_lat = TO - 1;
      else             exec_lat = TO + 5;
      exec_err = ($urandom_range(0, 5) == 0);
      send_seq(q);
   endtask

   initial begin
      dtab[0] = 8'h70; dtab[1] = 8'h69; dtab[2] = 8'h72; dtab[3] = 8'h7A; dtab[4] = 8'h6B;
      dtab[5] = 8'h73; dtab[6] = 8'h74; dtab[7] = 8'h6C; dtab[8] = 8'h75; dtab[9] = 8'h7D;
      alu_if.alu_done = 0; alu_if.alu_result = '0; alu_if.alu_err = 0;
      rand_exec_bytes = 0;
      model_reset();

      repeat (2) @(negedge clk);
      check_eq("rst_state", state_o, SA);
      check_eq("rst_alu_a", alu_if.alu_a, 0);
      check_eq("rst_alu_op", alu_if.alu_op, 0);
      check_eq("rst_start", alu_if.alu_start, 0);
      check_eq("rst_disp", disp_value, 0);
      check_eq("rst_err", disp_err, 0);
      rst = 1;
      cycle();
      check_outputs();

      // 12 + 3 with release codes interleaved
      exec_lat = 2; exec_err = 0;
      send_seq('{8'h69, 8'hF0, 8'h69, 8'h72, 8'hF0, 8'h72, 8'h79, 8'hF0, 8'h79,
                 8'h7A, 8'hF0, 8'h7A, 8'h5A});
      check_eq("t1_disp", disp_value, 15);
      check_eq("t1_state", state_o, SSHOW);

      exec_lat = 1; exec_err = 0;
      send_seq('{8'h7C, 8'h72, 8'h5A});
`ifdef CALC_CHAIN_EN
      check_eq("chain_disp", disp_value, 30);
`else
      check_eq("nochain_disp", disp_value, 2);
      check_eq("nochain_state", state_o, SA);
`endif
      send_byte(8'h76);

      send_seq('{8'h69, 8'h72, 8'h7A, 8'h6B, 8'h73});
      check_eq("t2_max_digits", disp_value, 1234);
      send_seq('{8'h76, 8'h79});
      check_eq("t2_empty_op", state_o, SA);

      exec_lat = 0; exec_err = 1;
      send_seq('{8'h7D, 8'h7D, 8'hE0, 8'h4A, 8'h70, 8'h5A});
      check_eq("t3_err", disp_err, 1);
      check_eq("t3_state", state_o, SERR);
      send_seq('{8'h69, 8'h76});
      check_eq("t3_clear", state_o, SA);

      exec_lat = TO + 5; exec_err = 0;
      send_seq('{8'h69, 8'h79, 8'h72, 8'h5A});
      check_eq("t4_timeout", state_o, SERR);
      send_byte(8'h76);

      exec_lat = 5; exec_err = 0;
      exec_bytes = '{8'hF0, 8'h72};
      send_seq('{8'h69, 8'h79, 8'h69, 8'h5A});
      send_byte(8'h73);
      check_eq("t5_after_release", disp_value, 5);

      rand_exec_bytes = 1;
      for (int i = 0; i < 500; i++) send_random_token();

      // Reset in the middle of an execution.
      exec_lat = TO + 5;
      send_seq('{8'h76, 8'h69, 8'h79, 8'h72});
      code_valid = 1; code = 8'h5A;
      cycle();
      code_valid = 0;
      check_eq("t6_start", alu_if.alu_start, 1);
      cycle();
      #2 rst = 0;
      #1;
      check_eq("t6_rst_state", state_o, SA);
      check_eq("t6_rst_start", alu_if.alu_start, 0);
      check_eq("t6_rst_alu_b", alu_if.alu_b, 0);
      @(negedge clk);
      rst = 1;
      model_reset();
      alu_if.alu_done = 1; alu_if.alu_err = 0; alu_if.alu_result = 16'd99;
      cycle();
      alu_if.alu_done = 0;
      check_outputs();

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
